simmem_row_delay_calc: RTL and testbench

Single-bank DRAM timing model for the simulated memory controller. It accepts one AXI address request at a time (read or write, tagged with its internal identifier), derives a service cost from the row-buffer state and burst length, and holds the request for that many cycles. It then issues a release handshake downstream to the write-response or read-data bank, which frees the matching stored response. It sits between address-request ingress and the response banks, and uses the system and AXI dimensions from `simmem_pkg`.

---
 rtl/simmem_row_delay_calc.sv | 113 +++++++++++
 tb/tb_simmem_row_delay_calc.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/simmem_row_delay_calc.sv
// Single-bank DRAM timing model: charges each accepted request a row-buffer
// dependent cost in cycles, then hands its internal id to the response bank.

package simmem_pkg;
    localparam int AxAddrWidth            = 16;
    localparam int AxLenWidth             = 8;
    localparam int RowBufferLenWidth      = 8;
    localparam int WriteRespBankAddrWidth = 5;
    localparam int RowHitCost             = 10;
    localparam int PrechargeCost          = 50;
    localparam int ActivationCost         = 45;
endpackage

module simmem_row_delay_calc #(
    parameter int AddrWidth      = simmem_pkg::AxAddrWidth,
    parameter int LenWidth       = simmem_pkg::AxLenWidth,
    parameter int RowBufLenWidth = simmem_pkg::RowBufferLenWidth,
    parameter int IidWidth       = simmem_pkg::WriteRespBankAddrWidth,
    parameter int RowHitCost     = simmem_pkg::RowHitCost,
    parameter int PrechargeCost  = simmem_pkg::PrechargeCost,
    parameter int ActivationCost = simmem_pkg::ActivationCost,
    parameter int CostWidth      = $clog2(PrechargeCost + ActivationCost + RowHitCost + 2**LenWidth)
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic                            req_valid_i,
    output logic                            req_ready_o,
    input  logic [AddrWidth-1:0]            req_addr_i,
    input  logic [LenWidth-1:0]             req_burst_len_i,
    input  logic                            req_is_write_i,
    input  logic [IidWidth-1:0]             req_iid_i,
    output logic                            rel_valid_o,
    input  logic                            rel_ready_i,
    output logic [IidWidth-1:0]             rel_iid_o,
    output logic                            rel_is_write_o,
    output logic [CostWidth-1:0]            rel_cost_o,
    output logic                            row_open_o,
    output logic [AddrWidth-RowBufLenWidth-1:0] open_row_o
);

    localparam int RowWidth = AddrWidth - RowBufLenWidth;

    typedef enum logic [1:0] {
        IDLE,
        SERVE,
        RELEASE
    } state_e;

    state_e               state;
    logic [CostWidth-1:0] cnt;
    logic [CostWidth-1:0] req_cost;
    logic [RowWidth-1:0]  req_row;

    assign req_row     = req_addr_i[AddrWidth-1:RowBufLenWidth];
    assign req_ready_o = (state == IDLE);

    // Only the start address picks the row; row-crossing bursts pay once.
    always_comb begin
        req_cost = CostWidth'(RowHitCost) + CostWidth'(req_burst_len_i);
        if (!row_open_o) begin
            req_cost = req_cost + CostWidth'(ActivationCost);
        end else if (open_row_o != req_row) begin
            req_cost = req_cost + CostWidth'(PrechargeCost + ActivationCost);
        end
    end

    // Counter holds cost-1 after acceptance so the release lands at t+cost.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state          <= IDLE;
            cnt            <= '0;
            rel_valid_o    <= 1'b0;
            rel_iid_o      <= '0;
            rel_is_write_o <= 1'b0;
            rel_cost_o     <= '0;
            row_open_o     <= 1'b0;
            open_row_o     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid_i) begin
                        state          <= SERVE;
                        cnt            <= req_cost - 1'b1;
                        rel_iid_o      <= req_iid_i;
                        rel_is_write_o <= req_is_write_i;
                        rel_cost_o     <= req_cost;
                        row_open_o     <= 1'b1;
                        open_row_o     <= req_row;
                    end
                end
                SERVE: begin
                    if (cnt <= CostWidth'(1)) begin
                        state       <= RELEASE;
                        rel_valid_o <= 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                RELEASE: begin
                    if (rel_ready_i) begin
                        state       <= IDLE;
                        rel_valid_o <= 1'b0;
                    end
                end
                default: begin
                    state       <= IDLE;
                    rel_valid_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_simmem_row_delay_calc.sv
// Directed bench for simmem_row_delay_calc: row miss/hit/conflict costs,
// release back-pressure, reset in the middle of a service window.

module tb_simmem_row_delay_calc;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [15:0] req_addr;
    logic [7:0]  req_len;
    logic        req_wr;
    logic [4:0]  req_iid;
    logic        rel_valid;
    logic        rel_ready;
    logic [4:0]  rel_iid;
    logic        rel_wr;
    logic [8:0]  rel_cost;
    logic        row_open;
    logic [7:0]  open_row;

    int total = 0;
    int bad   = 0;

    simmem_row_delay_calc dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .req_valid_i     (req_valid),
        .req_ready_o     (req_ready),
        .req_addr_i      (req_addr),
        .req_burst_len_i (req_len),
        .req_is_write_i  (req_wr),
        .req_iid_i       (req_iid),
        .rel_valid_o     (rel_valid),
        .rel_ready_i     (rel_ready),
        .rel_iid_o       (rel_iid),
        .rel_is_write_o  (rel_wr),
        .rel_cost_o      (rel_cost),
        .row_open_o      (row_open),
        .open_row_o      (open_row)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drives one request for a single cycle; returns one cycle after acceptance.
    task automatic send_req(input logic [15:0] addr, input logic [7:0] len,
                            input logic wr, input logic [4:0] iid);
        req_valid = 1'b1;
        req_addr  = addr;
        req_len   = len;
        req_wr    = wr;
        req_iid   = iid;
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    // n counts cycles since acceptance; stops at first rel_valid or at limit.
    task automatic wait_rel(input int limit, output int n);
        n = 1;
        while (!rel_valid && n < limit) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic ack_rel();
        rel_ready = 1'b1;
        @(posedge clk); #1;
        rel_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        req_valid = 1'b0;
        rel_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL reset_req_ready got=%0b exp=1", req_ready); end
        total++; if (rel_valid !== 1'b0) begin bad++; $display("FAIL reset_rel_valid got=%0b exp=0", rel_valid); end
        total++; if (rel_iid !== 5'd0) begin bad++; $display("FAIL reset_rel_iid got=%0d exp=0", rel_iid); end
        total++; if (rel_wr !== 1'b0) begin bad++; $display("FAIL reset_rel_wr got=%0b exp=0", rel_wr); end
        total++; if (rel_cost !== 9'd0) begin bad++; $display("FAIL reset_rel_cost got=%0d exp=0", rel_cost); end
        total++; if (row_open !== 1'b0) begin bad++; $display("FAIL reset_row_open got=%0b exp=0", row_open); end
        total++; if (open_row !== 8'd0) begin bad++; $display("FAIL reset_open_row got=%0h exp=0", open_row); end
    endtask

    task automatic test_row_miss();
        int n;
        send_req(16'h0100, 8'd0, 1'b0, 5'd3);
        total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL miss_busy got=%0b exp=0", req_ready); end
        total++; if (row_open !== 1'b1) begin bad++; $display("FAIL miss_row_open got=%0b exp=1", row_open); end
        total++; if (open_row !== 8'h01) begin bad++; $display("FAIL miss_open_row got=%0h exp=01", open_row); end
        wait_rel(200, n);
        total++; if (n !== 55) begin bad++; $display("FAIL miss_latency got=%0d exp=55", n); end
        total++; if (rel_iid !== 5'd3) begin bad++; $display("FAIL miss_iid got=%0d exp=3", rel_iid); end
        total++; if (rel_wr !== 1'b0) begin bad++; $display("FAIL miss_wr got=%0b exp=0", rel_wr); end
        total++; if (rel_cost !== 9'd55) begin bad++; $display("FAIL miss_cost got=%0d exp=55", rel_cost); end
        total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL miss_ready_in_rel got=%0b exp=0", req_ready); end
        ack_rel();
        total++; if (rel_valid !== 1'b0) begin bad++; $display("FAIL miss_rel_drop got=%0b exp=0", rel_valid); end
        total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL miss_ready_back got=%0b exp=1", req_ready); end
    endtask

    // Burst from 0x01FC crosses into row 2 but is charged against row 1 only.
    task automatic test_row_hit();
        int n;
        send_req(16'h01FC, 8'd3, 1'b1, 5'd7);
        wait_rel(200, n);
        total++; if (n !== 13) begin bad++; $display("FAIL hit_latency got=%0d exp=13", n); end
        total++; if (rel_cost !== 9'd13) begin bad++; $display("FAIL hit_cost got=%0d exp=13", rel_cost); end
        total++; if (rel_wr !== 1'b1) begin bad++; $display("FAIL hit_wr got=%0b exp=1", rel_wr); end
        total++; if (rel_iid !== 5'd7) begin bad++; $display("FAIL hit_iid got=%0d exp=7", rel_iid); end
        total++; if (open_row !== 8'h01) begin bad++; $display("FAIL hit_open_row got=%0h exp=01", open_row); end
        ack_rel();
    endtask

    task automatic test_row_conflict();
        int n;
        send_req(16'h0200, 8'd0, 1'b0, 5'd9);
        total++; if (open_row !== 8'h02) begin bad++; $display("FAIL conf_open_row got=%0h exp=02", open_row); end
        wait_rel(300, n);
        total++; if (n !== 105) begin bad++; $display("FAIL conf_latency got=%0d exp=105", n); end
        total++; if (rel_cost !== 9'd105) begin bad++; $display("FAIL conf_cost got=%0d exp=105", rel_cost); end
        total++; if (rel_iid !== 5'd9) begin bad++; $display("FAIL conf_iid got=%0d exp=9", rel_iid); end
        ack_rel();
    endtask

    task automatic test_max_cost();
        int n;
        send_req(16'h0300, 8'd255, 1'b0, 5'd31);
        wait_rel(600, n);
        total++; if (n !== 360) begin bad++; $display("FAIL max_latency got=%0d exp=360", n); end
        total++; if (rel_cost !== 9'd360) begin bad++; $display("FAIL max_cost got=%0d exp=360", rel_cost); end
        total++; if (rel_iid !== 5'd31) begin bad++; $display("FAIL max_iid got=%0d exp=31", rel_iid); end
        total++; if (open_row !== 8'h03) begin bad++; $display("FAIL max_open_row got=%0h exp=03", open_row); end
        ack_rel();
    endtask

    task automatic test_release_stall();
        int n;
        int unstable;
        send_req(16'h0310, 8'd5, 1'b1, 5'd4);
        wait_rel(200, n);
        total++; if (n !== 15) begin bad++; $display("FAIL stall_latency got=%0d exp=15", n); end
        unstable = 0;
        for (int i = 0; i < 7; i++) begin
            if (i == 2) begin
                req_valid = 1'b1;
                req_addr  = 16'h0500;
                req_len   = 8'd0;
                req_wr    = 1'b0;
                req_iid   = 5'd1;
            end
            @(posedge clk); #1;
            req_valid = 1'b0;
            if (rel_valid !== 1'b1 || rel_iid !== 5'd4 || rel_wr !== 1'b1 ||
                rel_cost !== 9'd15 || req_ready !== 1'b0) unstable++;
        end
        total++; if (unstable !== 0) begin bad++; $display("FAIL stall_stable got=%0d bad cycles exp=0", unstable); end
        total++; if (open_row !== 8'h03) begin bad++; $display("FAIL stall_ignored_req got=%0h exp=03", open_row); end
        ack_rel();
        total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL stall_ready_back got=%0b exp=1", req_ready); end
        total++; if (rel_valid !== 1'b0) begin bad++; $display("FAIL stall_rel_drop got=%0b exp=0", rel_valid); end
    endtask

    task automatic test_reset_mid_serve();
        int n;
        int seen;
        test_reset();
        send_req(16'h0100, 8'd0, 1'b0, 5'd12);
        for (int i = 1; i < 20; i++) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        total++; if (row_open !== 1'b0) begin bad++; $display("FAIL midrst_row_open got=%0b exp=0", row_open); end
        total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL midrst_ready got=%0b exp=1", req_ready); end
        total++; if (rel_cost !== 9'd0) begin bad++; $display("FAIL midrst_cost got=%0d exp=0", rel_cost); end
        seen = 0;
        for (int i = 0; i < 80; i++) begin
            @(posedge clk); #1;
            if (rel_valid !== 1'b0) seen++;
        end
        total++; if (seen !== 0) begin bad++; $display("FAIL midrst_no_release got=%0d exp=0", seen); end
        send_req(16'h0100, 8'd0, 1'b0, 5'd2);
        wait_rel(200, n);
        total++; if (n !== 55) begin bad++; $display("FAIL midrst_latency got=%0d exp=55", n); end
        total++; if (rel_cost !== 9'd55) begin bad++; $display("FAIL midrst_cost_after got=%0d exp=55", rel_cost); end
        total++; if (rel_iid !== 5'd2) begin bad++; $display("FAIL midrst_iid got=%0d exp=2", rel_iid); end
        ack_rel();
    endtask

    // Each request is driven in the first cycle ready returns (cost+1 spacing).
    task automatic test_back_to_back();
        int n;
        send_req(16'h0110, 8'd1, 1'b0, 5'd5);
        wait_rel(200, n);
        total++; if (n !== 11) begin bad++; $display("FAIL b2b_first_latency got=%0d exp=11", n); end
        total++; if (rel_cost !== 9'd11) begin bad++; $display("FAIL b2b_first_cost got=%0d exp=11", rel_cost); end
        ack_rel();
        send_req(16'h0120, 8'd0, 1'b1, 5'd6);
        total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL b2b_accept got=%0b exp=0", req_ready); end
        wait_rel(200, n);
        total++; if (n !== 10) begin bad++; $display("FAIL b2b_second_latency got=%0d exp=10", n); end
        total++; if (rel_iid !== 5'd6) begin bad++; $display("FAIL b2b_second_iid got=%0d exp=6", rel_iid); end
        total++; if (rel_wr !== 1'b1) begin bad++; $display("FAIL b2b_second_wr got=%0b exp=1", rel_wr); end
        ack_rel();
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_addr  = '0;
        req_len   = '0;
        req_wr    = 1'b0;
        req_iid   = '0;
        rel_ready = 1'b0;
        test_reset();
        test_row_miss();
        test_row_hit();
        test_row_conflict();
        test_max_cost();
        test_release_stall();
        test_reset_mid_serve();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
